// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_onehot_arbiter
// Description : Round-robin arbiter for a shared resource. Issues a registered
//               grant in both one-hot and binary-index form, with a
//               valid/ready handshake, multi-beat lock and rotating priority.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-high reset
//               req_i        - request vector, bit i = requester i
//               lock_i       - hold the current grant for another beat on accept
//               gnt_ready_i  - consumer accepts the presented grant
//               gnt_valid_o  - a grant is being presented
//               gnt_onehot_o - one-hot grant (zero when not valid)
//               gnt_index_o  - binary index of the grant (zero when not valid)
//               ptr_o        - current round-robin priority pointer
// Revision    : 1.0 - initial release
// ============================================================================
module rr_onehot_arbiter #(
  parameter int WIDTH     = 4,
  parameter int IDXW      = $clog2(WIDTH),
  parameter int BACK2BACK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_i,
  input  logic             lock_i,
  input  logic             gnt_ready_i,
  output logic             gnt_valid_o,
  output logic [WIDTH-1:0] gnt_onehot_o,
  output logic [IDXW-1:0]  gnt_index_o,
  output logic [IDXW-1:0]  ptr_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state_q,  state_d;
  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic [IDXW-1:0]  index_q,  index_d;
  logic [IDXW-1:0]  ptr_q,    ptr_d;

  logic             w_any_req;
  logic [IDXW-1:0]  w_ptr_inc;
  logic [IDXW-1:0]  w_arb_ptr;
  logic             w_found;
  logic [IDXW-1:0]  w_win_idx;
  logic [WIDTH-1:0] w_win_onehot;
  logic             w_accept;

  assign w_any_req = |req_i;
  assign w_accept  = valid_q & gnt_ready_i;

  // Pointer advance wraps at WIDTH, not 2^IDXW, so non-power-of-two sizes
  // never produce an out-of-range index.
  assign w_ptr_inc = (index_q == IDXW'(WIDTH - 1)) ? '0 : index_q + 1'b1;

  // While a grant is up, the only time the winner is consumed is on an
  // unlocked accept, where the pointer is about to become w_ptr_inc. Using
  // that value here makes the just-served requester lowest priority for a
  // back-to-back arbitration.
  assign w_arb_ptr = (state_q == S_GRANT) ? w_ptr_inc : ptr_q;

  // Circular scan starting at w_arb_ptr; first set bit wins.
  always_comb begin
    int pos;
    w_found   = 1'b0;
    w_win_idx = '0;
    pos       = 0;
    for (int k = 0; k < WIDTH; k++) begin
      pos = int'(w_arb_ptr) + k;
      if (pos >= WIDTH) begin
        pos = pos - WIDTH;
      end
      if (!w_found && req_i[pos[IDXW-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = IDXW'(pos);
      end
    end
  end

  // Binary-to-one-hot conversion of the winner.
  for (genvar g = 0; g < WIDTH; g++) begin : g_onehot
    assign w_win_onehot[g] = w_found && (w_win_idx == IDXW'(g));
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    onehot_d = onehot_q;
    index_d  = index_q;
    ptr_d    = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          state_d  = S_GRANT;
          valid_d  = 1'b1;
          onehot_d = w_win_onehot;
          index_d  = w_win_idx;
        end
      end
      S_GRANT: begin
        // Lock holds the grant even if its request has dropped.
        if (w_accept && !lock_i) begin
          ptr_d = w_ptr_inc;
          if ((BACK2BACK != 0) && w_any_req) begin
            onehot_d = w_win_onehot;
            index_d  = w_win_idx;
          end else begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            onehot_d = '0;
            index_d  = '0;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        valid_d  = 1'b0;
        onehot_d = '0;
        index_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      index_q  <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
      index_q  <= index_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt_valid_o  = valid_q;
  assign gnt_onehot_o = onehot_q;
  assign gnt_index_o  = index_q;
  assign ptr_o        = ptr_q;

endmodule
`default_nettype wire

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Parametrised round-robin arbiter for the processor's shared-resource request buses, e.g. LSU/fetch ports to memory and writeback port sharing.
- Takes WIDTH request lines and issues one registered grant.
- Presents the grant in both one-hot and binary-index form, so downstream muxes can use either encoding.
- Adds a valid/ready grant handshake, lock (multi-beat hold) and rotating fairness.
- Contains the one-hot/binary conversion as internal logic.

Parameters:
- WIDTH, 4: number of requesters; legal range 2..32; need not be a power of two.
- IDXW, $clog2(WIDTH): binary index width (derived; do not override).
- BACK2BACK, 1: 1 = re-arbitrate on the same edge a grant is accepted; 0 = insert one IDLE cycle between grants.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  WIDTH  request vector; bit i = requester i wants the resource.
- lock  input  1  when high at acceptance, the current grant is held for another beat.
- gnt_ready  input  1  consumer accepts the current grant this cycle.
- gnt_valid  output  1  a grant is being presented.
- gnt_onehot  output  WIDTH  one-hot grant; all-zero when gnt_valid=0.
- gnt_index  output  IDXW  binary index of the granted requester; 0 when gnt_valid=0.
- ptr  output  IDXW  current round-robin priority pointer (debug/verification).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; gnt_valid=0; gnt_onehot=0; gnt_index=0; ptr=0.
  - Reset takes effect immediately, even mid-grant; the pending grant is dropped with no acceptance.
- All outputs are registered; no combinational path from req/gnt_ready/lock to outputs.
- Winner selection (combinational, internal):
  - Scan req circularly starting at bit ptr: ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1.
  - The first set bit wins.
  - Wrap is modulo WIDTH, not 2^IDXW; index values ≥ WIDTH never occur.
- State IDLE:
  - If |req: latch winner into gnt_onehot/gnt_index, set gnt_valid=1, go to GRANT.
  - Latency is 1 cycle from req seen to gnt_valid.
  - Otherwise stay in IDLE.
- State GRANT:
  - gnt_valid=1; gnt_onehot and gnt_index are stable until acceptance.
  - Acceptance = gnt_valid & gnt_ready on a rising edge.
  - Accept with lock=1: keep the same grant, ptr unchanged, stay in GRANT. This applies even if that req bit has dropped; lock overrides.
  - Accept with lock=0: ptr ← (gnt_index+1) mod WIDTH.
    - If BACK2BACK=1 and |req, load a new winner computed with the updated ptr on the same edge; stay in GRANT.
    - The just-served requester is lowest priority for that arbitration.
    - Otherwise clear outputs and go to IDLE.
  - No accept: hold everything. The grant is not retracted if the granted req bit deasserts.
- Invariants:
  - gnt_onehot == (1 << gnt_index) whenever gnt_valid=1.
  - popcount(gnt_onehot) ≤ 1.
  - ptr changes only on an unlocked acceptance.
- Fairness: with all requesters continuously asserting and lock=0, each is granted exactly once per WIDTH accepted grants.

Test Plan:
- Reset and single request: WIDTH=4; assert rst mid-GRANT → outputs 0 immediately. Then req=4'b0100 → next cycle gnt_valid=1, gnt_onehot=0100, gnt_index=2; accept → ptr=3.
- Rotation: req=4'b1111 held, gnt_ready=1, BACK2BACK=1 → gnt_index sequence 0,1,2,3,0 on consecutive cycles with no bubble.
- Non-power-of-two wrap: WIDTH=5, ptr=4, req=5'b00011 → gnt_index=0. After accept ptr=1 (never 5..7).
- Backpressure and lock: grant idx 1 with gnt_ready=0 for 3 cycles → outputs stable. Accept with lock=1 → idx 1 re-granted, ptr unchanged. Accept with lock=0 → ptr=2.
- Req drop and mode: granted req bit deasserts before accept → grant held. With BACK2BACK=0 and req=1111 → gnt_valid low for exactly one cycle between grants.
- Random soak: random req/ready/lock against a reference model → one-hot/index consistency, no starvation beyond WIDTH unlocked grants.
